// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared constants, FSM states and register map for the SPI register-file master/slave.
package spi_reg_pkg;
  localparam int CMD_W = 8;
  localparam int WRITE_BIT = 7;
  localparam int STATUS = 0, ACTIONS = 1, P = 2, E = 3, M = 4, CONST = 5, C = 6, SPARE = 7;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
endpackage

// File: rtl/spi_reg_master_clk_tick.sv
// spi_clk_tick: CLK_DIV down-counter; tick marks the last clk cycle of a phase, load restarts the phase.
module spi_clk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= CW'(CLK_DIV - 1);
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign tick = cnt == '0;
endmodule

// File: rtl/spi_reg_master.sv
// spi_reg_master: SPI mode-0 master issuing one 16-bit command+data frame per register read/write request.
module spi_reg_master
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter int REG_W   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [REG_W-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [REG_W-1:0]  rsp_rdata,
  output logic              busy,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);
  localparam int FW = CMD_W + REG_W;
  state_t state, state_nx;
  logic tick, load, ph, ph_nx, wr, acc, sclk_d, cs_off, first_gap;
  logic [3:0] bitc, bitc_nx;
  logic [FW-1:0] sr;
  logic [REG_W-1:0] rx;
  logic [CMD_W-1:0] cmd;

  spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .load(load), .tick(tick));

  assign req_ready = state == IDLE;
  assign busy = !req_ready;
  assign acc = req_valid && req_ready;
  assign cs_off = state == IDLE || state == GAP;
  assign sclk_d = state == SHIFT && ph;
  assign first_gap = state == GAP && !spi_cs_n;

  always_comb begin
    cmd = CMD_W'(req_addr);
    cmd[WRITE_BIT] = req_write;
  end

  // SHIFT starts in the high phase: SETUP already served as the first low phase
  always_comb begin
    state_nx = state;
    ph_nx = ph;
    bitc_nx = bitc;
    load = tick;
    case (state)
      IDLE: begin
        load = acc;
        if (acc) state_nx = SETUP;
      end
      SETUP: if (tick) begin
        state_nx = SHIFT;
        ph_nx = 1'b1;
        bitc_nx = '0;
      end
      SHIFT: if (tick) begin
        ph_nx = !ph;
        if (!ph) begin
          bitc_nx = bitc + 4'd1;
          if (bitc == 4'd15) state_nx = HOLD;
        end
      end
      HOLD: if (tick) state_nx = GAP;
      GAP: if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ph <= 1'b0;
      bitc <= '0;
      sr <= '0;
      rx <= '0;
      wr <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_clk <= 1'b0;
      spi_mosi <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nx;
      ph <= ph_nx;
      bitc <= bitc_nx;
      spi_cs_n <= cs_off;
      spi_clk <= sclk_d;
      rsp_valid <= first_gap;
      if (first_gap && !wr) rsp_rdata <= rx;
      if (sclk_d && !spi_clk) rx <= {rx[REG_W-2:0], spi_miso};
      if (acc) begin
        sr <= {cmd, req_write ? req_wdata : {REG_W{1'b0}}};
        wr <= req_write;
      end
      if (state == SETUP) spi_mosi <= sr[FW-1];
      else if (spi_clk && !sclk_d) begin
        spi_mosi <= sr[FW-2];
        sr <= sr << 1;
      end else if (cs_off) spi_mosi <= 1'b0;
    end
endmodule

// File: doc/spi_reg_master.md
# spi_reg_master

SPI mode-0 master that issues single-register read/write transactions to the SPI register-file slave used on our Tiny Tapeout tops (8 registers × 8 bits: status, actions, P, E, M, Const, C, spare). It converts a valid/ready request into one 16-bit chip-select frame and returns read data on a one-cycle response strobe. It drives the RSA register map from an on-chip sequencer and serves as the bus-functional master in top-level benches.

## Interface
- ADDR_W, 3, register address width; must be ≤ 7
- REG_W, 8, register data width; fixed at 8
- CLK_DIV, 4, SCLK half-period in clk cycles; must be ≥ 1

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; transfer on req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  register address
- req_wdata  in  REG_W  write data; ignored for reads
- rsp_valid  out  1  one-cycle pulse at transaction end, reads and writes
- rsp_rdata  out  REG_W  read data; valid with rsp_valid on reads
- busy  out  1  high in every state except IDLE
- spi_cs_n  out  1  active-low chip select
- spi_clk  out  1  SCLK, idles low
- spi_mosi  out  1  master data out
- spi_miso  in  1  slave data in

## Operation
- Frame: command byte, then data byte, MSB first. Command = {req_write, (7-ADDR_W) zeros, req_addr}.
- Write: data byte on MOSI = req_wdata. Read: data byte on MOSI = 0x00; MISO sampled during data byte forms rsp_rdata. MISO ignored during the command byte.
- Request fields are latched into a 16-bit shift register on acceptance; later input changes have no effect.
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
  - IDLE: cs_n=1, sclk=0, req_ready=1. Acceptance → SETUP.
  - SETUP: cs_n=0, MOSI = bit 15; CLK_DIV cycles → SHIFT.
  - SHIFT: 16 SCLK periods. Rising edge samples MISO; falling edge shifts MOSI to next bit. After 16th falling edge → HOLD.
  - HOLD: cs_n=0, sclk=0, CLK_DIV cycles → GAP.
  - GAP: cs_n=1; rsp_valid=1 on first GAP cycle only; CLK_DIV cycles → IDLE.
- rsp_rdata loads on reads only; writes leave it unchanged.
- Requests during busy are not accepted (req_ready=0); requester holds req_valid.

## Timing
- Reset values: spi_cs_n=1, spi_clk=0, spi_mosi=0, rsp_valid=0, rsp_rdata=0, busy=0, req_ready=1. Reset mid-frame aborts immediately; no response is issued.
- All outputs registered except req_ready and busy, which decode state.
- Acceptance edge = cycle 0. cs_n falls at cycle 1.
- First SCLK rise at cycle 1+CLK_DIV; each SCLK level lasts CLK_DIV cycles.
- cs_n low for 34·CLK_DIV cycles: 136 at CLK_DIV=4.
- cs_n rises and rsp_valid pulses at cycle 1+34·CLK_DIV. req_ready returns CLK_DIV cycles later.
- Back-to-back period: 35·CLK_DIV+1 cycles.
- MISO sampled on the clk edge that drives SCLK high. The slave must present data by the end of the preceding low phase.

## Structure
- Package spi_reg_pkg holds CMD_W=8, WRITE_BIT=7, the state enum and the register-address constants (STATUS=0, ACTIONS=1, P=2, E=3, M=4, CONST=5, C=6, SPARE=7). The package is shared with the slave side and the top.
- Sub-module spi_clk_tick: CLK_DIV down-counter emitting a phase tick; it is reloaded on state entry. The FSM, bit counter (0–15) and shift registers live in spi_reg_master.

## Test plan
- Write addr 2, data 0xA5 → MOSI frame 0x82 0xA5; slave reg 2 = 0xA5; one rsp_valid pulse; rsp_rdata unchanged.
- Read addr 6, slave model returns 0x3C → MOSI 0x06 0x00; rsp_rdata = 0x3C with rsp_valid at cycle 137 (CLK_DIV=4).
- Back-to-back write of 0x01 to addr 1, then read addr 0 with req_valid held → second cs_n fall exactly 141 cycles after the first; req_ready low throughout.
- Change req_addr/req_wdata while busy → frame unaffected; no second acceptance until IDLE.
- Assert rst_n low after 5 SCLK periods → cs_n=1, sclk=0 immediately; no rsp_valid; a new read after release completes normally.
- CLK_DIV=1 read of 0x5A → cs_n low 34 cycles; correct data; 16 SCLK rises counted.
